// File: rtl/aes_out_serializer_if.sv
// -----------------------------------------------------------------------------
// aes_out_serializer_if
// Beat-level valid/ready bus from the AES output serializer toward the
// transmit shift register.
//
// Signals:
//   tx_data   OUT_W  current beat, ciphertext MSB end first
//   tx_valid  1      tx_data holds a beat
//   tx_ready  1      sink accepts the beat when tx_valid & tx_ready
//   tx_last   1      final beat of a 128-bit block
//
// Modports:
//   master  serializer side (drives data/valid/last, samples ready)
//   slave   sink side
// -----------------------------------------------------------------------------
interface aes_out_serializer_if #(
    parameter int OUT_W = 8
);
    logic [OUT_W-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             tx_last;

    modport master (
        output tx_data,
        output tx_valid,
        output tx_last,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  tx_last,
        output tx_ready
    );
endinterface

// File: rtl/aes_out_serializer.sv
// -----------------------------------------------------------------------------
// aes_out_serializer
// Captures finished 132-bit packets from the AES pipeline controller, buffers
// the 128-bit ciphertexts in a DEPTH-entry FIFO and streams each block
// MSB-first as 128/OUT_W beats of OUT_W bits over a valid/ready handshake.
//
// Parameters:
//   DEPTH   FIFO capacity in blocks (power of two, >= 2)
//   OUT_W   beat width (8, 16, 32 or 64)
//   ROUNDS  expected round count of a finished packet (round check only)
//
// Ports:
//   clk         rising-edge clock
//   n_rst       asynchronous active-low reset
//   data_in     [131:4] ciphertext, [3:0] round count
//   data_valid  one packet per high cycle
//   buf_full    FIFO holds DEPTH blocks
//   blk_count   blocks waiting in the FIFO (not the one being sent)
//   overflow    sticky: a packet was dropped because the FIFO was full
//   tx          beat bus (aes_out_serializer_if.master)
//   round_err   sticky: a packet with a wrong round count was rejected
//               (present only when AES_OUT_ROUND_CHECK_EN is defined)
//
// Configuration macro:
//   AES_OUT_ROUND_CHECK_EN  enables the round-count check and round_err port.
// -----------------------------------------------------------------------------
module aes_out_serializer #(
    parameter int DEPTH  = 4,
    parameter int OUT_W  = 8,
    parameter int ROUNDS = 10
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic [131:0]               data_in,
    input  logic                       data_valid,
    output logic                       buf_full,
    output logic [$clog2(DEPTH+1)-1:0] blk_count,
    output logic                       overflow,
    aes_out_serializer_if.master       tx
`ifdef AES_OUT_ROUND_CHECK_EN
    ,
    output logic                       round_err
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int BEATS = 128 / OUT_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [3:0] ROUND_VAL = 4'(ROUNDS);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND
    } state_t;

    state_t              state_q, state_d;
    logic [127:0]        mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [127:0]        sreg;
    logic [BEAT_W-1:0]   beat;
    logic                pkt_ok;
    logic                push;
    logic                pop;
    logic                shift;
    logic                last_beat;

`ifdef AES_OUT_ROUND_CHECK_EN
    assign pkt_ok = (data_in[3:0] == ROUND_VAL);
`else
    // Round field is ignored in this build.
    logic unused_round;
    assign unused_round = ^{data_in[3:0], ROUND_VAL};
    assign pkt_ok       = 1'b1;
`endif

    // buf_full comes from the registered count, so a pop in the same cycle
    // never makes room for a write.
    assign buf_full  = (count == CNT_W'(DEPTH));
    assign blk_count = count;
    assign push      = data_valid && !buf_full && pkt_ok;
    assign last_beat = (beat == BEAT_W'(BEATS - 1));
    assign tx.tx_data = sreg[127 -: OUT_W];

    // NOTE: every signal written here gets a default first, otherwise a path
    // that skips the assignment infers a latch.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        shift       = 1'b0;
        tx.tx_valid = 1'b0;
        tx.tx_last  = 1'b0;
        case (state_q)
            IDLE: begin
                if (count != '0) state_d = LOAD;
            end
            LOAD: begin
                pop     = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                tx.tx_valid = 1'b1;
                tx.tx_last  = last_beat;
                if (tx.tx_ready) begin
                    shift = 1'b1;
                    // count excludes this cycle's push: no bypass into LOAD.
                    if (last_beat) state_d = (count != '0) ? LOAD : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: the storage array carries no reset; only pointers and count are
    // reset, which makes stale contents unreachable.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in[131:4];
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sreg <= '0;
            beat <= '0;
        end else if (pop) begin
            sreg <= mem[rd_ptr];
            beat <= '0;
        end else if (shift) begin
            sreg <= sreg << OUT_W;
            beat <= beat + BEAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)                       overflow <= 1'b0;
        else if (data_valid && buf_full)  overflow <= 1'b1;
    end

`ifdef AES_OUT_ROUND_CHECK_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)                      round_err <= 1'b0;
        else if (data_valid && !pkt_ok)  round_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_aes_out_serializer.sv
// -----------------------------------------------------------------------------
// tb_aes_out_serializer
// Directed and randomized checks of aes_out_serializer (DEPTH=4, OUT_W=8).
// The expected output is a queue of bytes built from every accepted block;
// a negedge monitor consumes it on each accepted beat and checks stability
// of stalled beats.
// -----------------------------------------------------------------------------
module tb_aes_out_serializer;

    localparam int DEPTH = 4;
    localparam int OUT_W = 8;
    localparam logic [3:0] RND_OK = 4'hA;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic         clk;
    logic         n_rst;
    logic [131:0] data_in;
    logic         data_valid;
    logic         buf_full;
    logic [2:0]   blk_count;
    logic         overflow;
`ifdef AES_OUT_ROUND_CHECK_EN
    logic         round_err;
`endif

    aes_out_serializer_if #(.OUT_W(OUT_W)) bus ();

    aes_out_serializer #(.DEPTH(DEPTH), .OUT_W(OUT_W), .ROUNDS(10)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .buf_full   (buf_full),
        .blk_count  (blk_count),
        .overflow   (overflow),
        .tx         (bus)
`ifdef AES_OUT_ROUND_CHECK_EN
        ,
        .round_err  (round_err)
`endif
    );

    int    tests = 0;
    int    fails = 0;
    beat_t exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic void expect_block(input logic [127:0] ct);
        for (int i = 0; i < 16; i++) begin
            beat_t b;
            b.data = ct[127 - 8*i -: 8];
            b.last = (i == 15);
            exp_q.push_back(b);
        end
    endfunction

    // One cycle of data_valid with the given packet.
    task automatic push_pkt(input logic [127:0] ct, input logic [3:0] rnd);
        data_in    = {ct, rnd};
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
    endtask

    task automatic apply_reset();
        n_rst = 1'b0;
        exp_q.delete();
        #2;
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_tx_last", bus.tx_last, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_blk_count", blk_count, 0);
        check("rst_buf_full", buf_full, 0);
        check("rst_overflow", overflow, 0);
`ifdef AES_OUT_ROUND_CHECK_EN
        check("rst_round_err", round_err, 0);
`endif
        tick();
        tick();
        n_rst = 1'b1;
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        tick();
        tick();
        check({tag, "_drained"}, 128'(exp_q.size()), 0);
        check({tag, "_idle"}, bus.tx_valid, 0);
        check({tag, "_count"}, blk_count, 0);
    endtask

    // Beat monitor: consumes expected bytes on every accepted beat and checks
    // that a stalled beat stays put.
    logic       stalled = 1'b0;
    logic [7:0] held_data;
    logic       held_last;

    always @(negedge clk) begin
        if (!n_rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", bus.tx_valid, 1);
                check("stall_data", bus.tx_data, held_data);
                check("stall_last", bus.tx_last, held_last);
            end
            if (bus.tx_valid && bus.tx_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_beat", bus.tx_data, {1'b1, 8'h00});
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_data", bus.tx_data, e.data);
                    check("beat_last", bus.tx_last, e.last);
                end
            end
            stalled   = bus.tx_valid && !bus.tx_ready;
            held_data = bus.tx_data;
            held_last = bus.tx_last;
        end
    end

    initial begin
        logic [127:0] blk [6];
        logic [127:0] ct;
        logic [3:0]   rnd;
        logic [2:0]   prev_cnt;
        logic         mono;

        n_rst        = 1'b1;
        data_in      = '0;
        data_valid   = 1'b0;
        bus.tx_ready = 1'b0;
        #1;

        // Reset values.
        apply_reset();

        // Single known packet, tx_ready held high: latency and 16 consecutive beats.
        bus.tx_ready = 1'b1;
        ct = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        expect_block(ct);
        push_pkt(ct, RND_OK);                           // edge N
        check("lat_n_valid", bus.tx_valid, 0);
        check("lat_n_count", blk_count, 1);
        tick();                                         // edge N+1
        check("lat_n1_valid", bus.tx_valid, 0);
        tick();                                         // edge N+2
        check("lat_n2_valid", bus.tx_valid, 1);
        check("lat_n2_data", bus.tx_data, 8'h00);
        check("lat_n2_count", blk_count, 0);
        for (int i = 0; i < 16; i++) tick();
        check("single_consecutive", 128'(exp_q.size()), 0);
        check("single_idle", bus.tx_valid, 0);

        // Same block with tx_ready toggling each cycle.
        bus.tx_ready = 1'b0;
        expect_block(ct);
        push_pkt(ct, RND_OK);
        for (int i = 0; i < 120 && exp_q.size() != 0; i++) begin
            bus.tx_ready = ~bus.tx_ready;
            tick();
        end
        bus.tx_ready = 1'b1;
        drain("toggle", 20);

        // Fill with the sink stalled: the first block moves into the
        // serializer, four more fill the FIFO, the sixth is dropped.
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) blk[i] = rand128();
        for (int i = 0; i < 6; i++) begin
            if (i < 5) expect_block(blk[i]);
            push_pkt(blk[i], RND_OK);
            if (i == 4) begin
                check("fill_full", buf_full, 1);
                check("fill_count4", blk_count, 4);
                check("fill_no_ovf", overflow, 0);
            end
        end
        check("drop_overflow", overflow, 1);
        check("drop_count", blk_count, 4);
        check("stalled_first", bus.tx_data, blk[0][127:120]);
        bus.tx_ready = 1'b1;
        mono     = 1'b1;
        prev_cnt = blk_count;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            tick();
            if (blk_count > prev_cnt) mono = 1'b0;
            prev_cnt = blk_count;
        end
        check("drain_monotonic", mono, 1);
        drain("overflow", 10);
        check("overflow_sticky", overflow, 1);
        apply_reset();

        // Push coinciding with the LOAD pop at count 2.
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            blk[i] = rand128();
            expect_block(blk[i]);
            push_pkt(blk[i], RND_OK);
        end
        check("pushpop_count", blk_count, 2);
        check("pushpop_sending", bus.tx_valid, 1);

        // Randomized traffic: random stalls, random pushes when space is
        // reported; many pointer wraps.
        for (int i = 0; i < 400; i++) begin
            bus.tx_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0 && !buf_full) begin
                ct = rand128();
`ifdef AES_OUT_ROUND_CHECK_EN
                rnd = RND_OK;
`else
                rnd = 4'($urandom_range(0, 15));
`endif
                data_in    = {ct, rnd};
                data_valid = 1'b1;
                expect_block(ct);
            end else begin
                data_valid = 1'b0;
            end
            tick();
        end
        data_valid   = 1'b0;
        bus.tx_ready = 1'b1;
        drain("random", 400);
        check("random_no_ovf", overflow, 0);

        // Reset at beat 7 of a block with two more buffered.
        for (int i = 0; i < 3; i++) begin
            blk[i] = rand128();
            expect_block(blk[i]);
            push_pkt(blk[i], RND_OK);
        end
        for (int i = 0; i < 7; i++) tick();
        check("mid_beat7", bus.tx_data, blk[0][127-56 -: 8]);
        check("mid_buffered", blk_count, 2);
        apply_reset();
        for (int i = 0; i < 4; i++) tick();
        check("post_rst_quiet", bus.tx_valid, 0);
        ct = rand128();
        expect_block(ct);
        push_pkt(ct, RND_OK);
        drain("post_rst", 40);

`ifdef AES_OUT_ROUND_CHECK_EN
        // Wrong round count is rejected; the next good packet goes through.
        ct = rand128();
        push_pkt(ct, 4'd9);
        check("round_err_set", round_err, 1);
        check("round_not_stored", blk_count, 0);
        check("round_no_ovf", overflow, 0);
        ct = rand128();
        expect_block(ct);
        push_pkt(ct, 4'd10);
        drain("round_ok", 40);
        check("round_err_sticky", round_err, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
